// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline register.
// Control-vector bit positions and main/skid slot state encoding.
package pipe_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W     = 10;

  localparam int CTRL_MEM_TO_REG = 0;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_ALU_LO     = 6;
  localparam int CTRL_ALU_HI     = 9;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  typedef logic [CTRL_W-1:0] ctrl_t;

  function automatic logic [3:0] ctrl_alu(
    input ctrl_t c
  );
    return c[CTRL_ALU_HI:CTRL_ALU_LO];
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload register of the pipeline stage.
// clr zeroes only ctrl and rd so a bubble never matches a hazard.
module pipe_stage_slot #(
  parameter int XLEN    = pipe_pkg::XLEN_DEF,
  parameter int NUM_OPS = 2,
  parameter int REG_AW  = pipe_pkg::REG_AW_DEF,
  parameter int CTRL_W  = pipe_pkg::CTRL_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ld,
  input  logic                      clr,
  input  logic [CTRL_W-1:0]         d_ctrl,
  input  logic [XLEN-1:0]           d_pc,
  input  logic [NUM_OPS*XLEN-1:0]   d_ops,
  input  logic [XLEN-1:0]           d_imm,
  input  logic [NUM_OPS*REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0]         d_rd,
  output logic [CTRL_W-1:0]         q_ctrl,
  output logic [XLEN-1:0]           q_pc,
  output logic [NUM_OPS*XLEN-1:0]   q_ops,
  output logic [XLEN-1:0]           q_imm,
  output logic [NUM_OPS*REG_AW-1:0] q_rs,
  output logic [REG_AW-1:0]         q_rd
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_ctrl <= '0;
      q_pc   <= '0;
      q_ops  <= '0;
      q_imm  <= '0;
      q_rs   <= '0;
      q_rd   <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
      q_rd   <= '0;
    end else if (ld) begin
      q_ctrl <= d_ctrl;
      q_pc   <= d_pc;
      q_ops  <= d_ops;
      q_imm  <= d_imm;
      q_rs   <= d_rs;
      q_rd   <= d_rd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for a registered-ready one-entry skid slot.
module pipe_stage_reg #(
  parameter int XLEN    = pipe_pkg::XLEN_DEF,
  parameter int NUM_OPS = 2,
  parameter int REG_AW  = pipe_pkg::REG_AW_DEF,
  parameter int CTRL_W  = pipe_pkg::CTRL_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [NUM_OPS*XLEN-1:0]   in_ops,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [NUM_OPS*REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0]         in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [XLEN-1:0]           out_pc,
  output logic [NUM_OPS*XLEN-1:0]   out_ops,
  output logic [XLEN-1:0]           out_imm,
  output logic [NUM_OPS*REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0]         out_rd
);

  import pipe_pkg::*;

  logic [1:0] st;
  logic [1:0] st_n;
  logic       in_fire;
  logic       m_ld;
  logic       m_clr;

  logic [CTRL_W-1:0]         m_ctrl;
  logic [XLEN-1:0]           m_pc;
  logic [NUM_OPS*XLEN-1:0]   m_ops;
  logic [XLEN-1:0]           m_imm;
  logic [NUM_OPS*REG_AW-1:0] m_rs;
  logic [REG_AW-1:0]         m_rd;

  assign in_fire = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_valid;
  logic s_ld;
  logic s_clr;
  logic from_skid;

  logic [CTRL_W-1:0]         s_ctrl;
  logic [XLEN-1:0]           s_pc;
  logic [NUM_OPS*XLEN-1:0]   s_ops;
  logic [XLEN-1:0]           s_imm;
  logic [NUM_OPS*REG_AW-1:0] s_rs;
  logic [REG_AW-1:0]         s_rd;

  assign in_ready = ~skid_valid;

  assign m_ctrl = from_skid ? s_ctrl : in_ctrl;
  assign m_pc   = from_skid ? s_pc   : in_pc;
  assign m_ops  = from_skid ? s_ops  : in_ops;
  assign m_imm  = from_skid ? s_imm  : in_imm;
  assign m_rs   = from_skid ? s_rs   : in_rs;
  assign m_rd   = from_skid ? s_rd   : in_rd;

  pipe_stage_slot #(
    .XLEN(XLEN), .NUM_OPS(NUM_OPS),
    .REG_AW(REG_AW), .CTRL_W(CTRL_W)
  ) u_skid (
    .clk(clk), .reset_n(reset_n),
    .ld(s_ld), .clr(s_clr),
    .d_ctrl(in_ctrl), .d_pc(in_pc),
    .d_ops(in_ops), .d_imm(in_imm),
    .d_rs(in_rs), .d_rd(in_rd),
    .q_ctrl(s_ctrl), .q_pc(s_pc),
    .q_ops(s_ops), .q_imm(s_imm),
    .q_rs(s_rs), .q_rd(s_rd)
  );
`else
  assign in_ready = out_ready | ~out_valid;

  assign m_ctrl = in_ctrl;
  assign m_pc   = in_pc;
  assign m_ops  = in_ops;
  assign m_imm  = in_imm;
  assign m_rs   = in_rs;
  assign m_rd   = in_rd;
`endif

  always_comb begin
    st_n  = st;
    m_ld  = 1'b0;
    m_clr = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    s_ld      = 1'b0;
    s_clr     = 1'b0;
    from_skid = 1'b0;
`endif
    if (flush) begin
      st_n  = ST_EMPTY;
      m_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      s_clr = 1'b1;
`endif
    end else begin
      unique case (1'b1)
        st == ST_EMPTY: begin
          if (in_fire) begin
            st_n = ST_FULL;
            m_ld = 1'b1;
          end
        end
        st == ST_FULL: begin
          if (out_ready) begin
            if (in_fire) begin
              m_ld = 1'b1;
            end else begin
              st_n  = ST_EMPTY;
              m_clr = 1'b1;
            end
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_fire) begin
            st_n = ST_SKID;
            s_ld = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        // Skid drains into main; in_ready is low so nothing new enters.
        st == ST_SKID: begin
          if (out_ready) begin
            st_n      = ST_FULL;
            m_ld      = 1'b1;
            from_skid = 1'b1;
            s_clr     = 1'b1;
          end
        end
`endif
        default: st_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_EMPTY;
      out_valid <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid <= 1'b0;
`endif
    end else begin
      st        <= st_n;
      out_valid <= (st_n != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
      skid_valid <= (st_n == ST_SKID);
`endif
    end
  end

  pipe_stage_slot #(
    .XLEN(XLEN), .NUM_OPS(NUM_OPS),
    .REG_AW(REG_AW), .CTRL_W(CTRL_W)
  ) u_main (
    .clk(clk), .reset_n(reset_n),
    .ld(m_ld), .clr(m_clr),
    .d_ctrl(m_ctrl), .d_pc(m_pc),
    .d_ops(m_ops), .d_imm(m_imm),
    .d_rs(m_rs), .d_rd(m_rd),
    .q_ctrl(out_ctrl), .q_pc(out_pc),
    .q_ops(out_ops), .q_imm(out_imm),
    .q_rs(out_rs), .q_rd(out_rd)
  );

endmodule
